sqrt_pipelined: RTL and testbench

- Fully pipelined unsigned integer square-root unit: root = floor(sqrt(radicand)).
- Restoring digit-by-digit algorithm with one pipeline stage per root bit.
- Accepts a new operand every clock; results emerge in issue order with a matching valid strobe.
- Used as a datapath arithmetic block fed by a start/data-valid handshake with no back-pressure.

---
 rtl/sqrt_pipelined.sv | 125 ++++++++++++
 tb/tb_sqrt_pipelined.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_pipelined.sv
// sqrt_pipelined: fully pipelined unsigned integer square root,
// root = floor(sqrt(radicand)), restoring digit-by-digit, one stage per root bit.
//
// Parameters:
//   INPUT_BITS   radicand width (>= 2, odd allowed)
//   OUTPUT_BITS  root width and pipeline depth (derived)
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   start       qualifies radicand this cycle
//   radicand    unsigned operand
//   data_valid  one-cycle strobe per issued operand, OUTPUT_BITS-1 edges after issue
//   root        result, held between strobes
//   remainder   radicand - root*root (only when SQRT_REMAINDER_EN is defined)
//
// Optional feature macro: SQRT_REMAINDER_EN
module sqrt_pipelined #(
    parameter int INPUT_BITS = 16,
    localparam int OUTPUT_BITS = INPUT_BITS / 2 + INPUT_BITS % 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [INPUT_BITS-1:0]  radicand,
    output logic                   data_valid,
    output logic [OUTPUT_BITS-1:0] root
`ifdef SQRT_REMAINDER_EN
    ,
    output logic [OUTPUT_BITS:0]   remainder
`endif
);

    localparam int EXT_BITS = 2 * OUTPUT_BITS;
    localparam int REM_BITS = OUTPUT_BITS + 1;
    localparam int SH_BITS  = REM_BITS + 2;

    // Odd widths gain a zero MSB so the operand splits into whole bit pairs.
    logic [EXT_BITS-1:0] w_rad_ext;
    assign w_rad_ext = EXT_BITS'(radicand);

    genvar k;
    generate
        for (k = 0; k < OUTPUT_BITS; k++) begin : g_stage
            // Radicand bits still unconsumed after this stage.
            localparam int LEFT = EXT_BITS - 2 * (k + 1);
`ifdef SQRT_REMAINDER_EN
            localparam bit KEEP_REM = 1'b1;
`else
            localparam bit KEEP_REM = (k < OUTPUT_BITS - 1);
`endif

            logic                   w_in_valid;
            logic                   w_load;
            logic [LEFT+1:0]        w_rad_src;
            logic [1:0]             w_pair;
            logic [OUTPUT_BITS-1:0] w_root_in;
            logic [REM_BITS-1:0]    w_rem_in;
            logic [SH_BITS-1:0]     w_rem_sh;
            logic [SH_BITS-1:0]     w_trial;
            logic                   w_ge;
            logic [OUTPUT_BITS-1:0] w_root_nx;
            logic                   r_valid;
            logic [OUTPUT_BITS-1:0] r_root;

            if (k == 0) begin : g_first
                assign w_in_valid = start;
                assign w_load     = 1'b1;
                assign w_rad_src  = w_rad_ext;
                assign w_root_in  = '0;
                assign w_rem_in   = '0;
            end else begin : g_next
                // Later stages only advance on a valid slot so root holds across bubbles.
                assign w_in_valid = g_stage[k-1].r_valid;
                assign w_load     = g_stage[k-1].r_valid;
                assign w_rad_src  = g_stage[k-1].g_rad.r_rad;
                assign w_root_in  = g_stage[k-1].r_root;
                assign w_rem_in   = g_stage[k-1].g_rem.r_rem;
            end

            assign w_pair    = w_rad_src[LEFT+1 -: 2];
            assign w_rem_sh  = {w_rem_in, w_pair};
            assign w_trial   = {1'b0, w_root_in, 2'b01};
            assign w_ge      = (w_rem_sh >= w_trial);
            assign w_root_nx = OUTPUT_BITS'({w_root_in, w_ge});

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_valid <= 1'b0;
                    r_root  <= '0;
                end else begin
                    r_valid <= w_in_valid;
                    if (w_load) r_root <= w_root_nx;
                end
            end

            if (LEFT > 0) begin : g_rad
                logic [LEFT-1:0] r_rad;
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n)    r_rad <= '0;
                    else if (w_load) r_rad <= w_rad_src[LEFT-1:0];
                end
            end

            if (KEEP_REM) begin : g_rem
                logic [REM_BITS-1:0] w_rem_nx;
                logic [REM_BITS-1:0] r_rem;
                // The restoring remainder never exceeds 2*root, so the low
                // REM_BITS of the difference are exact.
                assign w_rem_nx = w_ge ? (w_rem_sh[REM_BITS-1:0] - w_trial[REM_BITS-1:0])
                                       : w_rem_sh[REM_BITS-1:0];
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n)    r_rem <= '0;
                    else if (w_load) r_rem <= w_rem_nx;
                end
            end
        end
    endgenerate

    assign data_valid = g_stage[OUTPUT_BITS-1].r_valid;
    assign root       = g_stage[OUTPUT_BITS-1].r_root;
`ifdef SQRT_REMAINDER_EN
    assign remainder  = g_stage[OUTPUT_BITS-1].g_rem.r_rem;
`endif

endmodule

// File: tb/tb_sqrt_pipelined.sv
// tb_sqrt_pipelined: scoreboard bench for sqrt_pipelined at INPUT_BITS = 16, 4 and 5.
module tb_sqrt_pipelined;

    typedef struct {
        int root;
        int rem;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    logic        start16, start4, start5;
    logic [15:0] rad16;
    logic [3:0]  rad4;
    logic [4:0]  rad5;
    logic        dv16, dv4, dv5;
    logic [7:0]  root16;
    logic [1:0]  root4;
    logic [2:0]  root5;
`ifdef SQRT_REMAINDER_EN
    logic [8:0]  rem16;
    logic [2:0]  rem4;
    logic [3:0]  rem5;
`endif

    exp_t q16[$];
    exp_t q4[$];
    exp_t q5[$];
    exp_t e16, e4, e5;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sqrt_pipelined #(.INPUT_BITS(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .radicand(rad16),
        .data_valid(dv16), .root(root16)
`ifdef SQRT_REMAINDER_EN
        , .remainder(rem16)
`endif
    );

    sqrt_pipelined #(.INPUT_BITS(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .radicand(rad4),
        .data_valid(dv4), .root(root4)
`ifdef SQRT_REMAINDER_EN
        , .remainder(rem4)
`endif
    );

    sqrt_pipelined #(.INPUT_BITS(5)) u_dut5 (
        .clk(clk), .reset_n(reset_n), .start(start5), .radicand(rad5),
        .data_valid(dv5), .root(root5)
`ifdef SQRT_REMAINDER_EN
        , .remainder(rem5)
`endif
    );

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Each issue is sampled at the next edge; the result appears OUTPUT_BITS edges later.
    task automatic issue16(input int v, input int r, input int m);
        start16 = 1'b1;
        rad16 = 16'(v);
        q16.push_back('{root: r, rem: m, due: cyc + 8});
        step();
        start16 = 1'b0;
    endtask

    task automatic issue4(input int v, input int r, input int m);
        start4 = 1'b1;
        rad4 = 4'(v);
        q4.push_back('{root: r, rem: m, due: cyc + 2});
        step();
        start4 = 1'b0;
    endtask

    task automatic issue5(input int v, input int r, input int m);
        start5 = 1'b1;
        rad5 = 5'(v);
        q5.push_back('{root: r, rem: m, due: cyc + 3});
        step();
        start5 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q16.size() + q4.size() + q5.size()) > 0; i++) step();
        chk("drain_pending", q16.size() + q4.size() + q5.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset_n && dv16) begin
            if (q16.size() == 0) chk("unexpected_valid16", 1, 0);
            else begin
                e16 = q16.pop_front();
                chk("root16", int'(root16), e16.root);
                chk("latency16", cyc, e16.due);
`ifdef SQRT_REMAINDER_EN
                chk("rem16", int'(rem16), e16.rem);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && dv4) begin
            if (q4.size() == 0) chk("unexpected_valid4", 1, 0);
            else begin
                e4 = q4.pop_front();
                chk("root4", int'(root4), e4.root);
                chk("latency4", cyc, e4.due);
`ifdef SQRT_REMAINDER_EN
                chk("rem4", int'(rem4), e4.rem);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && dv5) begin
            if (q5.size() == 0) chk("unexpected_valid5", 1, 0);
            else begin
                e5 = q5.pop_front();
                chk("root5", int'(root5), e5.root);
                chk("latency5", cyc, e5.due);
`ifdef SQRT_REMAINDER_EN
                chk("rem5", int'(rem5), e5.rem);
`endif
            end
        end
    end

    int roots4[16] = '{0, 1, 1, 1, 2, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3};
    int rems4[16]  = '{0, 0, 1, 2, 0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 5, 6};

    initial begin
        start16 = 1'bx; start4 = 1'bx; start5 = 1'bx;
        rad16 = 'x; rad4 = 'x; rad5 = 'x;
        repeat (3) step();
        chk("reset_valid16", int'(dv16), 0);
        chk("reset_root16", int'(root16), 0);
        chk("reset_valid4", int'(dv4), 0);
        chk("reset_root4", int'(root4), 0);
        chk("reset_valid5", int'(dv5), 0);
        chk("reset_root5", int'(root5), 0);

        start16 = 1'b0; start4 = 1'b0; start5 = 1'b0;
        rad16 = '0; rad4 = '0; rad5 = '0;
        reset_n = 1'b1;
        repeat (10) step();
        chk("idle_valid16", int'(dv16), 0);
        chk("idle_valid4", int'(dv4), 0);
        chk("idle_valid5", int'(dv5), 0);

        // 4-bit sweep, one start every other cycle
        for (int i = 0; i < 16; i++) begin
            issue4(i, roots4[i], rems4[i]);
            step();
        end
        drain();

        // 16-bit back-to-back, including squares and square-minus-one
        issue16(81, 9, 0);
        issue16(80, 8, 16);
        issue16(65535, 255, 510);
        issue16(0, 0, 0);
        issue16(1, 1, 0);
        issue16(255, 15, 30);
        issue16(256, 16, 0);
        issue16(65025, 255, 0);
        issue16(65024, 254, 508);
        drain();
        chk("hold_root16", int'(root16), 254);

        // odd width
        issue5(31, 5, 6);
        issue5(25, 5, 0);
        step();
        issue5(24, 4, 8);
        drain();

        // reset with operands in flight
        issue16(81, 9, 0);
        issue16(4, 2, 0);
        issue16(9, 3, 0);
        step();
        reset_n = 1'b0;
        #1;
        q16.delete();
        chk("midreset_valid16", int'(dv16), 0);
        chk("midreset_root16", int'(root16), 0);
        step();
        reset_n = 1'b1;
        repeat (12) step();
        chk("post_reset_valid16", int'(dv16), 0);
        issue16(144, 12, 0);
        drain();
        chk("hold_after_reset16", int'(root16), 12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
